pass_done_monitor: RTL and testbench

PASS_DONE_MONITOR -- requirements
Module: pass_done_monitor

---
 rtl/mips_cpu_pkg.sv | 30 +++
 rtl/pass_done_ifc.sv | 10 +
 rtl/pass_done_fifo.sv | 51 +++++
 rtl/pass_done_monitor.sv | 99 +++++++++
 tb/tb_pass_done_monitor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MTC0 report types for the pass/done monitor: code encoding, monitor
// state, report word layout and a packing helper.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MTC0_NOOP = 2'd0,
    MTC0_PASS = 2'd1,
    MTC0_FAIL = 2'd2,
    MTC0_DONE = 2'd3
  } MTC0Code;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } PassDoneState;

  localparam int unsigned RPT_VALUE_W  = 16;
  localparam int unsigned RPT_CODE_W   = 2;
  localparam int unsigned RPT_PAD_LO_W = 8;
  localparam int unsigned RPT_PAD_HI_W = 6;
  localparam int unsigned RPT_DATA_W   = RPT_PAD_HI_W + RPT_CODE_W + RPT_PAD_LO_W + RPT_VALUE_W;

  function automatic logic [RPT_DATA_W-1:0] pack_rpt(input MTC0Code code,
                                                      input logic [RPT_VALUE_W-1:0] value);
    return {{RPT_PAD_HI_W{1'b0}}, code, {RPT_PAD_LO_W{1'b0}}, value};
  endfunction

endpackage

// File: rtl/pass_done_ifc.sv
// MTC0 report channel from mips_core: a 16-bit value tagged with an MTC0Code.
interface pass_done_ifc;
  import mips_cpu_pkg::*;

  logic [RPT_VALUE_W-1:0] value;
  MTC0Code                code;

  modport out (output value, code);
  modport in  (input  value, code);
endinterface

// File: rtl/pass_done_fifo.sv
// Report FIFO, power-of-2 depth; a push on a full FIFO is taken only if a pop
// frees a slot in the same cycle.
module pass_done_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pass_done_monitor.sv
// Counts MTC0 PASS/FAIL reports, streams every accepted report out of a FIFO and
// flags final status once DONE has drained. PASS_DONE_CYCLE_COUNT_EN enables cycle_count.
module pass_done_monitor
  import mips_cpu_pkg::*;
#(
  parameter int unsigned RPT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pass_done_ifc.in              pd,
  output logic [15:0]           pass_count,
  output logic [15:0]           fail_count,
  output logic [15:0]           last_value,
  output logic                  done,
  output logic                  passed,
  output logic                  failed,
  output logic                  overflow,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [RPT_DATA_W-1:0] rpt_data,
  output logic [31:0]           cycle_count
);
  PassDoneState          r_state;
  logic [15:0]           r_pass_count;
  logic [15:0]           r_fail_count;
  logic [15:0]           r_last_value;
  logic                  r_overflow;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_drop;
  logic [RPT_DATA_W-1:0] w_rpt_entry;

  assign w_accept    = (pd.code != MTC0_NOOP) && ((r_state == IDLE) || (r_state == RUN));
  assign w_rpt_entry = pack_rpt(pd.code, pd.value);
  // A full FIFO still takes the push when the consumer pops in the same cycle.
  assign w_drop      = w_accept && w_full && !(rpt_ready && !w_empty);

  pass_done_fifo #(
    .DEPTH(RPT_DEPTH),
    .WIDTH(RPT_DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_accept),
    .i_data (w_rpt_entry),
    .i_pop  (rpt_ready),
    .o_data (rpt_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pass_count <= '0;
      r_fail_count <= '0;
      r_last_value <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_accept) begin
      r_last_value <= pd.value;
      if (pd.code == MTC0_PASS && r_pass_count != '1) r_pass_count <= r_pass_count + 1'b1;
      if (pd.code == MTC0_FAIL && r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (pd.code == MTC0_DONE)  r_state <= DRAIN;
      else if (r_state == IDLE)  r_state <= RUN;
    end else if (r_state == DRAIN && w_empty) begin
      r_state <= HALT;
      r_done  <= 1'b1;
    end
  end

`ifdef PASS_DONE_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (((r_state == RUN) || (r_state == IDLE && w_accept)) && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

  assign pass_count = r_pass_count;
  assign fail_count = r_fail_count;
  assign last_value = r_last_value;
  assign overflow   = r_overflow;
  assign done       = r_done;
  assign passed     = r_done && (r_fail_count == '0) && (r_pass_count != '0);
  assign failed     = r_done && !passed;
  assign rpt_valid  = !w_empty;
endmodule

// File: tb/tb_pass_done_monitor.sv
// Randomized and directed bench for pass_done_monitor with a queue scoreboard on the report stream.
module tb_pass_done_monitor;
  import mips_cpu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rpt_ready = 1'b0;
  logic [15:0] pass_count, fail_count, last_value;
  logic        done, passed, failed, overflow, rpt_valid;
  logic [31:0] rpt_data, cycle_count;

  pass_done_ifc pd_if ();

  pass_done_monitor #(.RPT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pd         (pd_if),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .last_value (last_value),
    .done       (done),
    .passed     (passed),
    .failed     (failed),
    .overflow   (overflow),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_data   (rpt_data),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  // reference model
  int          m_phase, m_pass, m_fail, m_last, m_occ;
  bit          m_ovf;
  longint      m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_pass = 0; m_fail = 0; m_last = 0; m_occ = 0; m_ovf = 0; m_cyc = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input MTC0Code code, input logic [15:0] value, input logic ready);
    bit ev, acc, pop;
    ev  = (code != MTC0_NOOP);
    acc = ev && (m_phase == M_IDLE || m_phase == M_RUN);
    pop = ready && (m_occ > 0);
    if ((m_phase == M_RUN || (m_phase == M_IDLE && ev)) && m_cyc < 64'hFFFF_FFFF) m_cyc++;
    if (acc) begin
      m_last = int'(value);
      if (code == MTC0_PASS && m_pass < 65535) m_pass++;
      if (code == MTC0_FAIL && m_fail < 65535) m_fail++;
      if (m_occ < int'(DEPTH) || pop) begin
        exp_q.push_back((32'(code) << 24) | 32'(value));
        m_occ++;
      end else begin
        m_ovf = 1'b1;
      end
      if (code == MTC0_DONE) m_phase = M_DRAIN;
      else if (m_phase == M_IDLE) m_phase = M_RUN;
    end else if (m_phase == M_DRAIN && m_occ == 0) begin
      m_phase = M_HALT;
    end
    if (pop) m_occ--;
  endtask

  task automatic check_all();
    bit exp_done, exp_passed;
    exp_done   = (m_phase == M_HALT);
    exp_passed = exp_done && m_fail == 0 && m_pass != 0;
    chk("pass_count", 32'(pass_count), 32'(m_pass));
    chk("fail_count", 32'(fail_count), 32'(m_fail));
    chk("last_value", 32'(last_value), 32'(m_last));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("rpt_valid",  32'(rpt_valid),  32'(m_occ > 0));
    chk("done",       32'(done),       32'(exp_done));
    chk("passed",     32'(passed),     32'(exp_passed));
    chk("failed",     32'(failed),     32'(exp_done && !exp_passed));
`ifdef PASS_DONE_CYCLE_COUNT_EN
    chk("cycle_count", cycle_count, 32'(m_cyc));
`else
    chk("cycle_count", cycle_count, 32'd0);
`endif
  endtask

  // Drive one cycle of stimulus, predict its edge, then check the result.
  task automatic step(input MTC0Code code, input logic [15:0] value, input logic ready);
    rst = 1'b0; pd_if.code = code; pd_if.value = value; rpt_ready = ready;
    model_edge(code, value, ready);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pd_if.code  = MTC0Code'($urandom_range(1, 3));
    pd_if.value = 16'($urandom);
    rpt_ready   = 1'($urandom);
    model_reset();
    @(posedge clk); #1;
    check_all();
  endtask

  function automatic MTC0Code rand_code();
    int r = $urandom_range(0, 99);
    if (r < 50) return MTC0_NOOP;
    if (r < 75) return MTC0_PASS;
    if (r < 90) return MTC0_FAIL;
    return MTC0_DONE;
  endfunction

  task automatic wait_halt();
    for (int i = 0; i < 40; i++) begin
      if (m_phase == M_HALT) break;
      step(MTC0_NOOP, 16'h0, 1'b1);
    end
    chk("halt_reached", 32'(done), 32'd1);
  endtask

  // Scoreboard: every report handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rpt_unexpected: got 0x%08h expected no entry at %0t", rpt_data, $time);
      end else begin
        chk("rpt_data", rpt_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    pd_if.code = MTC0_NOOP; pd_if.value = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // two passes then done
    step(MTC0_PASS, 16'd1, 1'b1);
    step(MTC0_PASS, 16'd2, 1'b1);
    step(MTC0_DONE, 16'd0, 1'b1);
    wait_halt();
    chk("t1_pass_count", 32'(pass_count), 32'd2);
    chk("t1_passed", 32'(passed), 32'd1);

    // a failure makes the run fail
    do_reset();
    step(MTC0_PASS, 16'd5, 1'b1);
    step(MTC0_FAIL, 16'hBEEF, 1'b1);
    step(MTC0_DONE, 16'h0000, 1'b1);
    wait_halt();
    chk("t2_fail_count", 32'(fail_count), 32'd1);
    chk("t2_failed", 32'(failed), 32'd1);

    // overflow with a stalled consumer; DONE waits for the drain
    do_reset();
    for (int i = 0; i < 6; i++) step(MTC0_PASS, 16'(i + 16'h10), 1'b0);
    chk("t3_pass_count", 32'(pass_count), 32'd6);
    chk("t3_overflow", 32'(overflow), 32'd1);
    step(MTC0_DONE, 16'h7, 1'b0);
    for (int i = 0; i < 3; i++) step(MTC0_NOOP, 16'h0, 1'b0);
    chk("t3_done_held", 32'(done), 32'd0);
    wait_halt();

    // full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 4; i++) step(MTC0_PASS, 16'(i), 1'b0);
    step(MTC0_PASS, 16'h55, 1'b1);
    chk("t4_overflow", 32'(overflow), 32'd0);
    step(MTC0_DONE, 16'h1, 1'b1);
    wait_halt();

    // events after halt are ignored
    for (int i = 0; i < 5; i++) step(MTC0Code'($urandom_range(1, 3)), 16'($urandom), 1'b1);
    chk("t5_pass_frozen", 32'(pass_count), 32'd5);
    chk("t5_last_frozen", 32'(last_value), 32'd1);

    // reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 3; i++) step(MTC0_PASS, 16'(i + 1), 1'b0);
    step(MTC0_DONE, 16'h9, 1'b0);
    step(MTC0_NOOP, 16'h0, 1'b0);
    do_reset();
    chk("t6_rpt_valid", 32'(rpt_valid), 32'd0);
    step(MTC0_NOOP, 16'h0, 1'b1);
    chk("t6_rpt_valid_after", 32'(rpt_valid), 32'd0);

    // run length: PASS on cycle 10, DONE on cycle 19
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      if (c == 10)      step(MTC0_PASS, 16'hA, 1'b1);
      else if (c == 19) step(MTC0_DONE, 16'hB, 1'b1);
      else              step(MTC0_NOOP, 16'h0, 1'b1);
    end
`ifdef PASS_DONE_CYCLE_COUNT_EN
    chk("t7_cycle_count", cycle_count, 32'd10);
`else
    chk("t7_cycle_count", cycle_count, 32'd0);
`endif
    wait_halt();

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(10, 40)); i++)
        step(rand_code(), 16'($urandom), 1'($urandom));
      if (m_phase == M_IDLE || m_phase == M_RUN) step(MTC0_DONE, 16'($urandom), 1'b1);
      wait_halt();
      for (int i = 0; i < 4; i++) step(rand_code(), 16'($urandom), 1'($urandom));
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
